// File: rtl/prescaler_mc_pkg.sv
// Shared definitions for the multi-channel prescaler: size limits, the
// channel output mode, and the channel-index width helper.
package prescaler_lib;

  localparam int MAX_CHANNELS      = 16;
  localparam int MAX_COUNTER_WIDTH = 32;

  typedef enum logic {
    PRESC_PULSE  = 1'b0,
    PRESC_TOGGLE = 1'b1
  } presc_mode_t;

  // A single channel still needs a one-bit index port.
  function automatic int ch_idx_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/prescaler_mc_ch.sv
// One prescaler channel: programmable down-counter producing a tick strobe,
// an optional 50% toggle wave and a busy flag.
module prescaler_ch
  import prescaler_lib::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [CNT_W-1:0] div,
  input  presc_mode_t      mode,
  input  logic             en,
  input  logic             sync,
  output logic             tick,
  output logic             wave,
  output logic             busy
);

  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] cnt;
  presc_mode_t      mode_reg;
  logic             terminal;
  logic             clear_wave;

  assign terminal   = (cnt == '0);
  // Switching a channel to PULSE drops its wave on the write edge itself.
  assign clear_wave = wr && (mode == PRESC_PULSE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_reg  <= '0;
      mode_reg <= PRESC_PULSE;
      cnt      <= '0;
      tick     <= 1'b0;
      wave     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (wr) begin
        div_reg  <= div;
        mode_reg <= mode;
      end
      if (sync) begin
        // Sync beats terminal count; a same-cycle write bypasses into the counter.
        cnt  <= wr ? div : div_reg;
        tick <= 1'b0;
        wave <= 1'b0;
        busy <= en;
      end else if (!en) begin
        cnt  <= div_reg;
        tick <= 1'b0;
        busy <= 1'b0;
        if (clear_wave) wave <= 1'b0;
      end else begin
        busy <= 1'b1;
        if (terminal) begin
          // Reload uses the old divider, so a write lands at the following reload.
          cnt  <= div_reg;
          tick <= 1'b1;
          wave <= ((mode_reg == PRESC_TOGGLE) && !clear_wave) ? ~wave : 1'b0;
        end else begin
          cnt  <= cnt - CNT_W'(1);
          tick <= 1'b0;
          if ((mode_reg == PRESC_PULSE) || clear_wave) wave <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/prescaler_mc.sv
// Multi-channel programmable clock-enable generator: decodes the config write
// to one channel and replicates prescaler_ch N_CH times.
module prescaler_mc
  import prescaler_lib::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 16,
  parameter int CH_IDX_W = ch_idx_width(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_wr,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic                cfg_mode,
  input  logic [N_CH-1:0]     ch_en,
  input  logic                sync,
  output logic [N_CH-1:0]     tick,
  output logic [N_CH-1:0]     wave,
  output logic [N_CH-1:0]     busy
);

  if ((N_CH < 1) || (N_CH > MAX_CHANNELS)) begin : g_bad_n_ch
    $error("prescaler_mc: N_CH out of range");
  end
  if ((CNT_W < 1) || (CNT_W > MAX_COUNTER_WIDTH)) begin : g_bad_cnt_w
    $error("prescaler_mc: CNT_W out of range");
  end

  // Indices at or beyond N_CH match no channel, so such writes are dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr;

    assign wr = cfg_wr && (cfg_ch == CH_IDX_W'(i));

    prescaler_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .wr   (wr),
      .div  (cfg_div),
      .mode (presc_mode_t'(cfg_mode)),
      .en   (ch_en[i]),
      .sync (sync),
      .tick (tick[i]),
      .wave (wave[i]),
      .busy (busy[i])
    );
  end

endmodule

// File: tb/tb_prescaler_mc.sv
// Scoreboard bench for prescaler_mc: stimulus queues expected outputs per edge,
// a negedge monitor pops and compares them.
module tb_prescaler_mc;
  import prescaler_lib::*;

  localparam int N  = 5;
  localparam int W  = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_wr;
  logic [IW-1:0] cfg_ch;
  logic [W-1:0]  cfg_div;
  logic          cfg_mode;
  logic [N-1:0]  ch_en;
  logic          sync;
  logic [N-1:0]  tick;
  logic [N-1:0]  wave;
  logic [N-1:0]  busy;

  prescaler_mc #(
    .N_CH (N),
    .CNT_W(W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_wr  (cfg_wr),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_mode(cfg_mode),
    .ch_en   (ch_en),
    .sync    (sync),
    .tick    (tick),
    .wave    (wave),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           at;
    logic [N-1:0] mask;
    logic [N-1:0] t;
    logic [N-1:0] w;
    logic [N-1:0] b;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   last_edge;
  int   dv[N];
  logic md[N];

  task automatic checkOutput(input exp_t e);
    checks++;
    if (e.at != cyc)
      $display("[TB] FAIL %s: expectation for edge %0d reached the monitor at edge %0d", e.name, e.at, cyc);
    else if (((tick & e.mask) !== (e.t & e.mask)) || ((wave & e.mask) !== (e.w & e.mask)) ||
             ((busy & e.mask) !== (e.b & e.mask)))
      $display("[TB] FAIL %s @%0d: tick/wave/busy = %b/%b/%b, required %b/%b/%b (mask %b)",
               e.name, cyc, tick, wave, busy, e.t, e.w, e.b, e.mask);
    else
      passes++;
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic expectAt(input int at, input logic [N-1:0] mask, input logic [N-1:0] t,
                          input logic [N-1:0] w, input logic [N-1:0] b, input string name);
    exp_t e;
    e.at = at; e.mask = mask; e.t = t; e.w = w; e.b = b; e.name = name;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic wr, input logic [IW-1:0] ch, input logic [W-1:0] div,
                               input logic mode, input logic snc);
    @(negedge clk);
    cfg_wr = wr; cfg_ch = ch; cfg_div = div; cfg_mode = mode; sync = snc;
    last_edge = cyc + 1;
  endtask

  task automatic setEnable(input logic [N-1:0] en);
    @(negedge clk);
    ch_en = en; cfg_wr = 1'b0; sync = 1'b0;
    last_edge = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cfg_wr = 1'b0; sync = 1'b0;
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cfg_wr = 1'b0; sync = 1'b0;
    end
  endtask

  // Channels 0..3 enabled and freshly aligned at base; channel 4 idle.
  task automatic pushWindow(input int base, input int len, input string name);
    for (int k = 0; k <= len; k++) begin
      logic [N-1:0] t, w, b;
      t = '0; w = '0; b = '0;
      for (int i = 0; i < 4; i++) begin
        b[i] = 1'b1;
        t[i] = (k > 0) && (k % (dv[i] + 1) == 0);
        w[i] = md[i] && ((k / (dv[i] + 1)) % 2 == 1);
      end
      expectAt(base + k, '1, t, w, b, name);
    end
  endtask

  int e, s, r;

  initial begin
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    ch_en = '0; sync = 1'b0;
    for (int i = 0; i < N; i++) begin dv[i] = 0; md[i] = 1'b0; end

    idle(2);
    expectAt(cyc + 1, '1, '0, '0, '0, "reset_state");
    idle(1);
    rst_n = 1'b1;

    // Test 1: ch0 D=3 PULSE
    applyStimulus(1'b1, 3'd0, 16'd3, PRESC_PULSE, 1'b0);
    idle(1);
    setEnable(5'b00001);
    e = last_edge;
    for (int k = 0; k < 12; k++)
      expectAt(e + k, 5'b00001, {4'b0, (k % 4 == 3)}, 5'b0, 5'b00001, "t1_pulse_d3");
    idle(12);

    // Test 2: ch1 D=0 TOGGLE
    applyStimulus(1'b1, 3'd1, 16'd0, PRESC_TOGGLE, 1'b0);
    idle(1);
    setEnable(5'b00011);
    e = last_edge;
    for (int k = 0; k < 6; k++)
      expectAt(e + k, 5'b00010, 5'b00010, (k % 2 == 0) ? 5'b00010 : 5'b00000, 5'b00010, "t2_toggle_d0");
    idle(6);

    // Test 3: ch2 D=9, rewritten to D=4 while cnt=5
    applyStimulus(1'b1, 3'd2, 16'd9, PRESC_PULSE, 1'b0);
    idle(1);
    setEnable(5'b00111);
    e = last_edge;
    for (int k = 0; k < 20; k++)
      expectAt(e + k, 5'b00100, {2'b0, (k == 9 || k == 14 || k == 19), 2'b0}, 5'b0, 5'b00100, "t3_div_change");
    waitUntil(e + 2);
    applyStimulus(1'b1, 3'd2, 16'd4, PRESC_PULSE, 1'b0);
    waitUntil(e + 20);

    // Test 4: all channels, sync realignment and sync on a terminal count
    applyStimulus(1'b1, 3'd0, 16'd2, PRESC_PULSE, 1'b0);
    applyStimulus(1'b1, 3'd1, 16'd5, PRESC_TOGGLE, 1'b0);
    applyStimulus(1'b1, 3'd2, 16'd7, PRESC_PULSE, 1'b0);
    applyStimulus(1'b1, 3'd3, 16'd11, PRESC_TOGGLE, 1'b0);
    dv[0] = 2; md[0] = 1'b0; dv[1] = 5; md[1] = 1'b1;
    dv[2] = 7; md[2] = 1'b0; dv[3] = 11; md[3] = 1'b1;
    idle(1);
    setEnable(5'b01111);
    idle(7);
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    s = last_edge;
    pushWindow(s, 12, "t4_sync");
    waitUntil(s + 13);
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    s = last_edge;
    pushWindow(s, 12, "t4_sync_on_tc");

    // Test 5: write bypass on sync, then writes to out-of-range indices
    waitUntil(s + 13);
    applyStimulus(1'b1, 3'd3, 16'd6, PRESC_TOGGLE, 1'b1);
    s = last_edge;
    dv[3] = 6;
    pushWindow(s, 12, "t5_wr_sync_bypass");
    waitUntil(s + 12);
    applyStimulus(1'b1, 3'd5, 16'd1, PRESC_PULSE, 1'b0);
    applyStimulus(1'b1, 3'd7, 16'd1, PRESC_PULSE, 1'b0);
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    s = last_edge;
    pushWindow(s, 12, "t5_bad_index");

    // Test 6: reset where ch0 would tick, then disable/re-enable in TOGGLE
    waitUntil(s + 13);
    @(negedge clk);
    rst_n = 1'b0; ch_en = '0; cfg_wr = 1'b0; sync = 1'b0;
    r = cyc + 1;
    expectAt(r, '1, '0, '0, '0, "t6_reset_mid");
    expectAt(r + 1, '1, '0, '0, '0, "t6_after_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd1, 16'd2, PRESC_TOGGLE, 1'b0);
    idle(1);
    setEnable(5'b00010);
    e = last_edge;
    for (int k = 0; k < 3; k++)
      expectAt(e + k, 5'b00010, {3'b0, (k == 2), 1'b0}, {3'b0, (k >= 2), 1'b0}, 5'b00010, "t6_toggle_run");
    for (int k = 3; k < 5; k++)
      expectAt(e + k, 5'b00010, 5'b0, 5'b00010, 5'b0, "t6_disabled_hold");
    for (int k = 5; k < 8; k++)
      expectAt(e + k, 5'b00010, {3'b0, (k == 7), 1'b0}, {3'b0, (k < 7), 1'b0}, 5'b00010, "t6_reenable");
    idle(2);
    setEnable(5'b00000);
    idle(1);
    setEnable(5'b00010);
    idle(4);

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      checks++;
      $display("[TB] FAIL %s: edge %0d never checked (now %0d)", sb[0].name, sb[0].at, cyc);
      void'(sb.pop_front());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/prescaler_mc.md
Name: prescaler_mc

Overview:
Multi-channel, run-time-programmable clock-enable generator. It is the parametrised successor to the single fixed prescaler. Each of N_CH channels has its own divider register, enable and output mode (single-cycle tick or 50%-style toggle wave). A global sync input realigns every channel's phase. It sits between the system clock domain and peripheral timing logic (UART baud enables, LED blink, sample strobes).

Parameters:
- N_CH, 4, number of channels; range 1..prescaler_lib::MAX_CHANNELS (16).
- CNT_W, 16, divider/counter width; range 1..prescaler_lib::MAX_COUNTER_WIDTH (32). Elaboration error outside range.
- CH_IDX_W, $clog2(N_CH) (min 1), channel index width; derived, do not override.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_wr  in  1  single-cycle write strobe for channel config.
- cfg_ch  in  CH_IDX_W  target channel of write; index >= N_CH is ignored.
- cfg_div  in  CNT_W  divider value D; period = D+1 cycles.
- cfg_mode  in  1  0 = PULSE, 1 = TOGGLE.
- ch_en  in  N_CH  per-channel run enable (level).
- sync  in  1  global phase restart, single-cycle.
- tick  out  N_CH  per-channel one-cycle strobe at each terminal count (both modes).
- wave  out  N_CH  per-channel toggle output (TOGGLE mode); held 0 in PULSE mode.
- busy  out  N_CH  per-channel: 1 while enabled and counting.

Behaviour:
- Reset (rst_n=0 at an edge): div_reg=0, mode_reg=PULSE, cnt=0, tick=0, wave=0, busy=0 on all channels. Reset mid-count aborts immediately; no trailing tick.
- Config write: on an edge with cfg_wr=1 and cfg_ch<N_CH, div_reg[cfg_ch]<=cfg_div and mode_reg[cfg_ch]<=cfg_mode.
  - A new divider takes effect at the next reload only; the current period completes unchanged (glitch-free).
  - A mode change to PULSE clears wave at the next edge.
- Channel disabled (ch_en[i]=0): cnt<=div_reg, tick=0, busy=0, wave holds its last value.
- Channel enabled, no sync:
  - If cnt==0: tick<=1, cnt<=div_reg. In TOGGLE mode, wave<=~wave.
  - Else: cnt<=cnt-1, tick<=0.
  - busy=1.
- First tick after enable: ch_en sampled high at edge E with cnt=D gives tick high in the cycle after edge E+D. That is, D+1 cycles from enable to first tick, then every D+1 cycles.
- D=0: tick is high every cycle while enabled; in TOGGLE mode wave toggles every cycle (f/2).
- TOGGLE period is 2(D+1) cycles, duty exactly 50%.
- sync=1 (any channel state):
  - cnt<=div_reg, tick<=0, wave<=0. Next tick is D+1 cycles after the sync edge.
  - Sync priority: sync overrides terminal count in the same cycle, so no tick is emitted.
  - If cfg_wr targets channel i in the same cycle, cnt reloads with cfg_div (bypass), not the old div_reg.
- Simultaneous cfg_wr and terminal count on the same channel: reload uses the old div_reg; the new value applies from the next reload.
- Arithmetic: the counter is unsigned CNT_W bits and never wraps below 0. cfg_div is used full width, no truncation.
- Latency: all outputs registered; no combinational input-to-output path.

Decomposition:
- Extend package prescaler_lib:
  - Add MAX_CHANNELS = 16.
  - Add typedef enum logic {PRESC_PULSE=1'b0, PRESC_TOGGLE=1'b1} presc_mode_t.
  - Keep MAX_COUNTER_WIDTH = 32 as the CNT_W bound.
- Sub-module prescaler_ch: one channel, covering div_reg, mode_reg, counter, tick/wave/busy.
  - Ports: clk, rst_n, wr, div, mode, en, sync.
  - Top: generate-loop of N_CH instances plus cfg_ch decode to per-channel wr.

Test Plan:
1. Reset then write ch0 D=3 PULSE, raise ch_en[0] -> first tick 4 cycles later, then every 4 cycles; wave[0]=0, busy[0]=1.
2. ch1 D=0 TOGGLE enabled -> tick[1] constant 1; wave[1] alternates 0,1,0,1 each cycle.
3. ch2 D=9 running, write D=4 mid-period (cnt=5) -> current period ends on original schedule (10 cycles); subsequent ticks every 5 cycles.
4. All channels enabled with D=2,5,7,11; pulse sync at arbitrary cycle -> no tick in that cycle; wave all 0; next ticks at sync+3, +6, +8, +12; sync coinciding with a terminal count yields no tick.
5. cfg_wr to ch3 (D=6) in the same cycle as sync -> ch3 next tick at sync+7. Write with cfg_ch=N_CH (N_CH not power of 2, e.g. N_CH=3) -> no register change.
6. Assert rst_n=0 mid-period, then drop ch_en during TOGGLE with wave=1 -> reset: all outputs 0 next edge. Disable: tick=0, busy=0, wave holds 1, re-enable gives first tick after D+1 cycles.
